grad_spi_sched: RTL and testbench
=================================

Name: grad_spi_sched

Overview:
- Serial scheduler between the gradient BRAM output stage and four SPI gradient DACs.
- Captures each gradient word and its per-channel valid mask into per-channel pending slots.
- Shares one SPI shift engine between the channels by round-robin arbitration.
- Returns busy_o and data_lost_o, which feed the BRAM stage's serial-busy and data-lost inputs.

Parameters:
- N_CH, 4, number of DAC channels (chip selects).
- DATA_W, 24, bits shifted per DAC transfer, MSB first.
- DIV_W, 6, width of the SPI clock divisor input.

Ports:
- S_AXI_ACLK  in  1  system clock.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- data_i  in  32  gradient word. [23:0] is the DAC payload; [31:24] is ignored.
- valid_i  in  N_CH  one-cycle strobe per channel; data_i is sampled on the same edge.
- spi_clk_div_i  in  DIV_W  SPI half-period in clocks minus one.
- busy_o  out  1  a transfer is active or any slot is pending.
- data_lost_o  out  1  one-cycle pulse when a pending word is overwritten.
- sclk_o  out  1  shared SPI clock, idle low.
- sdo_o  out  1  shared SPI data.
- cs_n_o  out  N_CH  active-low chip selects, at most one low at a time.

Behaviour:
- Reset (async assert, sync release):
  - cs_n_o all ones; sclk_o, sdo_o, busy_o and data_lost_o 0.
  - All pending slots cleared; FSM in IDLE; round-robin pointer set so channel 0 has top priority.
- Capture: on an edge with valid_i[c]=1, pend_data[c] <= data_i[23:0] and pend[c] <= 1. Several bits may be set; every selected channel gets the same word.
- Overrun:
  - If valid_i[c]=1 while pend[c]=1 and channel c is not granted that edge, the new word overwrites the old one.
  - data_lost_o pulses high on the next cycle. Multiple channels overrunning on one edge give a single pulse.
  - If valid_i[c] coincides with the grant of c, the grant takes the old word and the new word is kept pending. No loss is flagged.
- Arbitration:
  - In IDLE with any pend set, grant the first set channel after the last-served one (wrap-around).
  - On the grant: load the shift register from pend_data, clear pend[g], latch H = spi_clk_div_i+1, and enter SETUP.
  - cs_n_o[g] falls on the grant edge. Grant latency is 2 clocks from the valid_i sample edge when idle.
- FSM, with a phase counter counting H clocks per phase:
  - IDLE: entered from reset and from GAP.
  - SETUP: 1 phase. cs_n low, sclk low, sdo = bit 23.
  - SHIFT: 24 bits, each 2 phases: sclk high for H, then sclk low for H. sdo shifts to the next bit when sclk falls; the DAC samples on the rising edge.
  - HOLD: 1 phase. cs_n low, sclk low.
  - GAP: 1 phase. All cs_n high, then return to IDLE.
  - A transfer occupies 51*H clocks from grant to return to IDLE.
- Divisor: changes to spi_clk_div_i mid-transfer are ignored; the new value applies at the next grant.
- Busy: busy_o = (state != IDLE) | (|pend). Registered, so it lags internal state by 1 clock.
- Bit counter is 5 bits and counts 0..23. The phase counter is DIV_W+1 bits, so H = 64 is representable.
- Reset mid-operation: all outputs return to reset values immediately. Any partial transfer is abandoned and not resumed.

Decomposition:
- Shared package (grad_pkg):
  - FSM state encoding (IDLE, SETUP, SHIFT, HOLD, GAP).
  - DAC word width (24) and channel count (4), so the BRAM stage and this block agree.
- Sub-module: grad_spi_shift, the single-channel shift engine. It takes start, word and H, and returns done plus the sclk/sdo/cs timing.
- grad_spi_sched keeps the pending slots, overrun detection, round-robin arbiter and busy/lost flags.

Test Plan:
- Single channel: div=0, valid_i=0001, data_i=0x00ABCDEF.
  - cs_n_o=1110 for 50 clocks starting 2 clocks after the strobe.
  - 24 rising sclk edges sample 0xABCDEF MSB first.
  - busy_o high for 52 clocks; data_lost_o stays 0.
- Broadcast: div=0, valid_i=1111, data 0x123456.
  - Channels served in order 0,1,2,3, each 51 clocks, all carrying 0x123456.
  - busy_o continuously high for 205 clocks; no loss.
- Overrun: valid_i=0011 with 0x111111, then during ch0's SHIFT valid_i=0010 with 0x222222.
  - data_lost_o pulses once.
  - ch1 transmits 0x222222.
  - Repeating the test with the strobe on the grant edge of ch1 gives no pulse, and ch1 transmits twice (0x111111, then 0x222222).
- Fairness: ch3 pending while ch0 is re-strobed every transfer. Order is ch0, ch3, ch0, ch0; ch3 waits at most one transfer.
- Divisor: div=30 gives a 62-clock sclk period and a 1581-clock transfer. Changing div to 0 mid-SHIFT leaves the current transfer unchanged; the next transfer takes 51 clocks.
- Reset: assert S_AXI_ARESETN low mid-SHIFT with ch2 pending.
  - cs_n_o=1111, sclk_o=0, busy_o=0 immediately.
  - After release, no transfer occurs until a new strobe arrives; the new strobe completes normally.

Source files
------------

// File: rtl/grad_pkg.sv
// grad_pkg: constants and FSM encoding shared by the gradient BRAM stage and the SPI scheduler.
package grad_pkg;
    localparam int GRAD_N_CH   = 4;
    localparam int GRAD_DATA_W = 24;
    localparam int GRAD_DIV_W  = 6;

    typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP} st_t;
endpackage

// File: rtl/grad_spi_shift.sv
// grad_spi_shift: single SPI shift engine; one word per start, H clocks per phase, MSB first.
module grad_spi_shift
    import grad_pkg::*;
#(
    parameter int DATA_W = GRAD_DATA_W,
    parameter int DIV_W  = GRAD_DIV_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] word,
    input  logic [DIV_W:0]    h,
    output logic              done,
    output st_t               state,
    output logic              sclk,
    output logic              sdo,
    output logic              cs_act
);
    localparam int BC_W = $clog2(DATA_W);

    st_t               state_n;
    logic [DIV_W:0]    ph, ph_n, h_q, h_n;
    logic [BC_W-1:0]   bitc, bitc_n;
    logic [DATA_W-1:0] sr, sr_n;
    logic              half, half_n, ph_end;

    assign ph_end = ph == h_q - 1'b1;
    assign done   = (state == ST_GAP) && ph_end;
    assign sclk   = half;
    assign sdo    = sr[DATA_W-1];
    assign cs_act = state inside {ST_SETUP, ST_SHIFT, ST_HOLD};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ph    <= '0;
            h_q   <= '0;
            bitc  <= '0;
            sr    <= '0;
            half  <= 1'b0;
        end else begin
            state <= state_n;
            ph    <= ph_n;
            h_q   <= h_n;
            bitc  <= bitc_n;
            sr    <= sr_n;
            half  <= half_n;
        end
    end

    // GAP end doubles as a start point so back-to-back transfers need no idle cycle
    always_comb begin
        state_n = state;
        ph_n    = ph + 1'b1;
        h_n     = h_q;
        bitc_n  = bitc;
        sr_n    = sr;
        half_n  = half;
        if (state == ST_IDLE || done) begin
            state_n = start ? ST_SETUP : ST_IDLE;
            ph_n    = '0;
            sr_n    = start ? word : sr;
            h_n     = start ? h : h_q;
        end else if (ph_end) begin
            ph_n = '0;
            case (state)
                ST_SETUP: begin
                    state_n = ST_SHIFT;
                    half_n  = 1'b1;
                    bitc_n  = '0;
                end
                ST_SHIFT: begin
                    if (half) begin
                        half_n = 1'b0;
                        sr_n   = sr << 1;
                    end else if (bitc == BC_W'(DATA_W - 1)) begin
                        state_n = ST_HOLD;
                    end else begin
                        bitc_n = bitc + 1'b1;
                        half_n = 1'b1;
                    end
                end
                ST_HOLD: state_n = ST_GAP;
                default: state_n = ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/grad_spi_sched.sv
// grad_spi_sched: per-channel pending slots, round-robin arbitration onto one SPI engine,
// overrun detection and busy reporting back to the BRAM stage.
module grad_spi_sched
    import grad_pkg::*;
#(
    parameter int N_CH   = GRAD_N_CH,
    parameter int DATA_W = GRAD_DATA_W,
    parameter int DIV_W  = GRAD_DIV_W
) (
    input  logic             S_AXI_ACLK,
    input  logic             S_AXI_ARESETN,
    input  logic [31:0]      data_i,
    input  logic [N_CH-1:0]  valid_i,
    input  logic [DIV_W-1:0] spi_clk_div_i,
    output logic             busy_o,
    output logic             data_lost_o,
    output logic             sclk_o,
    output logic             sdo_o,
    output logic [N_CH-1:0]  cs_n_o
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]   pend, gnt_oh, sel_oh;
    logic [DATA_W-1:0] pend_data [N_CH];
    logic [CH_W-1:0]   last, g, idx;
    logic              start, eng_done, cs_act, unused_hi;
    logic [DIV_W:0]    h_in;
    st_t               eng_state;

    assign unused_hi = ^data_i[31:DATA_W];
    assign h_in      = {1'b0, spi_clk_div_i} + 1'b1;
    assign start     = (|pend) && (eng_state == ST_IDLE || eng_done);
    assign gnt_oh    = start ? N_CH'(1) << g : '0;
    assign cs_n_o    = ~(cs_act ? sel_oh : '0);

    // first pending channel after the last-served one, wrapping around
    always_comb begin
        g   = last;
        idx = '0;
        for (int i = N_CH; i >= 1; i--) begin
            idx = CH_W'((int'(last) + i) % N_CH);
            g   = pend[idx] ? idx : g;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            pend        <= '0;
            last        <= CH_W'(N_CH - 1);
            sel_oh      <= '0;
            busy_o      <= 1'b0;
            data_lost_o <= 1'b0;
        end else begin
            pend        <= valid_i | (pend & ~gnt_oh);
            data_lost_o <= |(valid_i & pend & ~gnt_oh);
            busy_o      <= (eng_state != ST_IDLE) || (|pend);
            last        <= start ? g : last;
            sel_oh      <= start ? gnt_oh : sel_oh;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        for (int c = 0; c < N_CH; c++)
            if (valid_i[c]) pend_data[c] <= data_i[DATA_W-1:0];
    end

    grad_spi_shift #(.DATA_W(DATA_W), .DIV_W(DIV_W)) u_shift (
        .clk    (S_AXI_ACLK),
        .rst_n  (S_AXI_ARESETN),
        .start  (start),
        .word   (pend_data[g]),
        .h      (h_in),
        .done   (eng_done),
        .state  (eng_state),
        .sclk   (sclk_o),
        .sdo    (sdo_o),
        .cs_act (cs_act)
    );
endmodule

// File: tb/tb_grad_spi_sched.sv
// tb_grad_spi_sched: directed tests of the SPI scheduler; a negedge monitor logs each
// chip-select window (channel, word sampled on rising sclk, length, start cycle, sclk period).
module tb_grad_spi_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_i = '0;
    logic [3:0]  valid_i = '0;
    logic [5:0]  div = '0;
    logic        busy_o, data_lost_o, sclk_o, sdo_o;
    logic [3:0]  cs_n_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {int ch; logic [23:0] w; int nb; int len; int st; int per;} xfer_t;
    xfer_t q[$];
    logic [3:0]  prev_cs = 4'hF;
    logic        prev_sclk = 1'b0;
    logic [23:0] sh = '0;
    int nb = 0, st = 0, ch = -1, last_rise = 0, per = 0;
    int busy_run = 0, busy_len = 0, busy_runs = 0, lost_hi = 0, multi_cs = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    grad_spi_sched dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .spi_clk_div_i (div),
        .busy_o        (busy_o),
        .data_lost_o   (data_lost_o),
        .sclk_o        (sclk_o),
        .sdo_o         (sdo_o),
        .cs_n_o        (cs_n_o)
    );

    always @(negedge clk) begin
        if (cs_n_o != 4'hF && prev_cs == 4'hF) begin
            st = cyc; nb = 0; sh = '0; per = 0; ch = -1;
            for (int i = 0; i < 4; i++) if (!cs_n_o[i]) ch = i;
        end
        if ($countones(~cs_n_o) > 1) multi_cs++;
        if (sclk_o && !prev_sclk) begin
            sh = {sh[22:0], sdo_o};
            nb++;
            if (nb > 1) per = cyc - last_rise;
            last_rise = cyc;
        end
        if (cs_n_o == 4'hF && prev_cs != 4'hF) q.push_back('{ch, sh, nb, cyc - st, st, per});
        if (busy_o) busy_run++;
        else if (busy_run > 0) begin busy_len = busy_run; busy_runs++; busy_run = 0; end
        if (data_lost_o) lost_hi++;
        prev_cs = cs_n_o;
        prev_sclk = sclk_o;
    end

    task automatic clear_log();
        q.delete();
        busy_len = 0; busy_runs = 0; lost_hi = 0; multi_cs = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid_i = '0;
        repeat (3) @(negedge clk);
        #1 clear_log();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic strobe(input logic [3:0] v, input logic [31:0] d, output int t);
        @(negedge clk);
        valid_i = v; data_i = d; t = cyc;
        @(negedge clk);
        valid_i = '0;
    endtask

    task automatic strobe_at(input logic [3:0] v, input logic [31:0] d, input int at);
        int t;
        while (cyc < at - 1) @(negedge clk);
        strobe(v, d, t);
    endtask

    task automatic wait_idle(input int max, input string nm);
        int n = 0;
        repeat (3) @(negedge clk);
        while ((busy_o || cs_n_o != 4'hF) && n < max) begin @(negedge clk); n++; end
        checks++;
        if (n >= max) begin errors++; $display("FAIL %s timeout: still busy after %0d cycles", nm, max); end
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks += 5;
        if (cs_n_o !== 4'hF) begin errors++; $display("FAIL reset cs_n: got %b want 1111", cs_n_o); end
        if (sclk_o !== 1'b0) begin errors++; $display("FAIL reset sclk: got %b want 0", sclk_o); end
        if (sdo_o !== 1'b0) begin errors++; $display("FAIL reset sdo: got %b want 0", sdo_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy_o); end
        if (data_lost_o !== 1'b0) begin errors++; $display("FAIL reset lost: got %b want 0", data_lost_o); end
    endtask

    task automatic test_single();
        int t;
        do_reset();
        div = 6'd0;
        strobe(4'b0001, 32'h5AAB_CDEF, t);
        wait_idle(200, "single");
        checks += 9;
        if (q.size() != 1) begin errors++; $display("FAIL single count: got %0d want 1", q.size()); end
        else begin
            if (q[0].ch != 0) begin errors++; $display("FAIL single ch: got %0d want 0", q[0].ch); end
            if (q[0].w !== 24'hABCDEF) begin errors++; $display("FAIL single word: got %h want abcdef", q[0].w); end
            if (q[0].nb != 24) begin errors++; $display("FAIL single bits: got %0d want 24", q[0].nb); end
            if (q[0].len != 50) begin errors++; $display("FAIL single cs len: got %0d want 50", q[0].len); end
            if (q[0].st != t + 2) begin errors++; $display("FAIL single latency: got %0d want %0d", q[0].st - t, 2); end
            if (q[0].per != 2) begin errors++; $display("FAIL single sclk period: got %0d want 2", q[0].per); end
        end
        if (busy_len != 52) begin errors++; $display("FAIL single busy len: got %0d want 52", busy_len); end
        if (lost_hi != 0) begin errors++; $display("FAIL single lost: got %0d want 0", lost_hi); end
    endtask

    task automatic test_broadcast();
        int t;
        do_reset();
        strobe(4'b1111, 32'h0012_3456, t);
        wait_idle(400, "broadcast");
        checks += 5;
        if (q.size() != 4) begin errors++; $display("FAIL bcast count: got %0d want 4", q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks += 3;
            if (q[i].ch != i) begin errors++; $display("FAIL bcast ch[%0d]: got %0d want %0d", i, q[i].ch, i); end
            if (q[i].w !== 24'h123456) begin errors++; $display("FAIL bcast word[%0d]: got %h want 123456", i, q[i].w); end
            if (q[i].st != t + 2 + 51 * i) begin errors++; $display("FAIL bcast start[%0d]: got %0d want %0d", i, q[i].st - t, 2 + 51 * i); end
        end
        if (busy_len != 205) begin errors++; $display("FAIL bcast busy len: got %0d want 205", busy_len); end
        if (busy_runs != 1) begin errors++; $display("FAIL bcast busy runs: got %0d want 1", busy_runs); end
        if (lost_hi != 0) begin errors++; $display("FAIL bcast lost: got %0d want 0", lost_hi); end
        if (multi_cs != 0) begin errors++; $display("FAIL bcast multi cs: got %0d want 0", multi_cs); end
    endtask

    task automatic test_overrun();
        int t;
        do_reset();
        strobe(4'b0011, 32'h0011_1111, t);
        strobe_at(4'b0010, 32'h0022_2222, t + 10);
        wait_idle(300, "overrun");
        checks += 2;
        if (lost_hi != 1) begin errors++; $display("FAIL overrun lost: got %0d want 1", lost_hi); end
        if (q.size() != 2) begin errors++; $display("FAIL overrun count: got %0d want 2", q.size()); end
        else begin
            checks += 2;
            if (q[1].ch != 1) begin errors++; $display("FAIL overrun ch: got %0d want 1", q[1].ch); end
            if (q[1].w !== 24'h222222) begin errors++; $display("FAIL overrun word: got %h want 222222", q[1].w); end
        end
    endtask

    task automatic test_grant_collision();
        int t;
        do_reset();
        strobe(4'b0011, 32'h0011_1111, t);
        strobe_at(4'b0010, 32'h0022_2222, t + 52);
        wait_idle(400, "collision");
        checks += 2;
        if (lost_hi != 0) begin errors++; $display("FAIL collision lost: got %0d want 0", lost_hi); end
        if (q.size() != 3) begin errors++; $display("FAIL collision count: got %0d want 3", q.size()); end
        else begin
            checks += 4;
            if (q[1].ch != 1 || q[2].ch != 1) begin errors++; $display("FAIL collision ch: got %0d,%0d want 1,1", q[1].ch, q[2].ch); end
            if (q[1].w !== 24'h111111) begin errors++; $display("FAIL collision old word: got %h want 111111", q[1].w); end
            if (q[2].w !== 24'h222222) begin errors++; $display("FAIL collision new word: got %h want 222222", q[2].w); end
            if (q[2].st != t + 104) begin errors++; $display("FAIL collision start: got %0d want 104", q[2].st - t); end
        end
    endtask

    task automatic test_fairness();
        int t, t2;
        logic [23:0] ew [4];
        int ec [4];
        ew = '{24'h0A0A0A, 24'h333333, 24'h0B0B0B, 24'h0C0C0C};
        ec = '{0, 3, 0, 0};
        do_reset();
        strobe(4'b0001, 32'h000A_0A0A, t);
        strobe(4'b1000, 32'h0033_3333, t2);
        strobe_at(4'b0001, 32'h000B_0B0B, t + 10);
        strobe_at(4'b0001, 32'h000C_0C0C, t + 110);
        wait_idle(400, "fairness");
        checks += 2;
        if (lost_hi != 0) begin errors++; $display("FAIL fair lost: got %0d want 0", lost_hi); end
        if (q.size() != 4) begin errors++; $display("FAIL fair count: got %0d want 4", q.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (q[i].ch != ec[i]) begin errors++; $display("FAIL fair ch[%0d]: got %0d want %0d", i, q[i].ch, ec[i]); end
            if (q[i].w !== ew[i]) begin errors++; $display("FAIL fair word[%0d]: got %h want %h", i, q[i].w, ew[i]); end
        end
    endtask

    task automatic test_divisor();
        int t;
        do_reset();
        div = 6'd30;
        strobe(4'b0011, 32'h0080_0001, t);
        while (cyc < t + 300) @(negedge clk);
        div = 6'd0;
        wait_idle(3000, "divisor");
        checks++;
        if (q.size() != 2) begin errors++; $display("FAIL div count: got %0d want 2", q.size()); end
        else begin
            checks += 6;
            if (q[0].per != 62) begin errors++; $display("FAIL div sclk period: got %0d want 62", q[0].per); end
            if (q[0].len != 1550) begin errors++; $display("FAIL div cs len: got %0d want 1550", q[0].len); end
            if (q[1].st - q[0].st != 1581) begin errors++; $display("FAIL div transfer: got %0d want 1581", q[1].st - q[0].st); end
            if (q[0].w !== 24'h800001) begin errors++; $display("FAIL div word: got %h want 800001", q[0].w); end
            if (q[1].per != 2) begin errors++; $display("FAIL div next period: got %0d want 2", q[1].per); end
            if (q[1].len != 50) begin errors++; $display("FAIL div next len: got %0d want 50", q[1].len); end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        do_reset();
        strobe(4'b0101, 32'h000F_0F0F, t);
        while (cyc < t + 20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (cs_n_o !== 4'hF) begin errors++; $display("FAIL midrst cs_n: got %b want 1111", cs_n_o); end
        if (sclk_o !== 1'b0) begin errors++; $display("FAIL midrst sclk: got %b want 0", sclk_o); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst busy: got %b want 0", busy_o); end
        repeat (2) @(negedge clk);
        #1 clear_log();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        checks += 2;
        if (q.size() != 0) begin errors++; $display("FAIL midrst resumed: got %0d transfers want 0", q.size()); end
        if (busy_runs != 0 || busy_run != 0) begin errors++; $display("FAIL midrst busy after release: got %0d want 0", busy_runs + busy_run); end
        strobe(4'b0100, 32'h0024_6813, t);
        wait_idle(200, "midrst");
        checks++;
        if (q.size() != 1) begin errors++; $display("FAIL midrst new count: got %0d want 1", q.size()); end
        else begin
            checks += 2;
            if (q[0].ch != 2) begin errors++; $display("FAIL midrst new ch: got %0d want 2", q[0].ch); end
            if (q[0].w !== 24'h246813) begin errors++; $display("FAIL midrst new word: got %h want 246813", q[0].w); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_broadcast();
        test_overrun();
        test_grant_collision();
        test_fairness();
        test_divisor();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
